regfile_nx10: RTL and testbench
===============================

Name: regfile_nx10

Overview:
- Parametrised register file; the multi-entry successor to the single 10-bit enable register.
- DEPTH entries of WIDTH bits, one write port, two independent read ports.
- Optional registered read stage; write-to-read forwarding.
- Serves as the architectural register file of the 10-bit ISA datapath, feeding the ALU operand muxes.

Parameters:
- WIDTH, 10: data width of each entry.
- DEPTH, 8: number of entries; need not be a power of two.
- AW, 3: address width; must satisfy 2**AW >= DEPTH.
- READ_REG, 0: 0 = combinational read; 1 = registered read, 1-cycle latency.
- BYPASS, 1: 1 = same-cycle write data forwarded to a matching read; 0 = read returns the stored (old) value.

Ports:
- CLK, in, 1: single clock; all state updates on posedge.
- RST, in, 1: synchronous, active-high reset.
- we, in, 1: write enable.
- waddr, in, AW: write address.
- wdata, in, WIDTH: write data.
- raddr_a, in, AW: read port A address.
- raddr_b, in, AW: read port B address.
- rdata_a, out, WIDTH: read port A data.
- rdata_b, out, WIDTH: read port B data.

Behaviour:
- Clocking/reset is fixed: one clock CLK; reset RST is synchronous and active-high.
- Reset:
  - At a posedge with RST=1, all DEPTH entries clear to 0.
  - In READ_REG=1, both output registers also clear to 0.
  - RST has priority over we; a write in a reset cycle is dropped.
- Power-up: entries and output registers initialise to 0.
- Write:
  - At a posedge with RST=0 and we=1, entry[waddr] <= wdata.
  - If waddr >= DEPTH, the write is ignored and no entry changes.
- Read value, per port p, computed identically for A and B:
  - val_p = wdata if BYPASS=1, we=1, RST=0, raddr_p==waddr and waddr<DEPTH.
  - Otherwise val_p = entry[raddr_p] if raddr_p<DEPTH.
  - Otherwise val_p = 0.
- READ_REG=0: rdata_p = val_p combinationally, zero latency. With BYPASS=1 the forward path is combinational from wdata/we/waddr.
- READ_REG=1:
  - rdata_p <= val_p at each posedge with RST=0; latency 1 cycle from address presentation.
  - A same-edge write to the read address is therefore captured as the new data when BYPASS=1, the old data when BYPASS=0.
  - Outputs hold between edges.
- Both ports may address the same entry, including the entry being written; both return the same value.
- Reset mid-operation: a pending READ_REG=1 read is discarded; outputs read 0 on the cycle after the reset edge.
- No internal state beyond entries and the optional output registers; no handshake, and every cycle is accepted.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: entry 0 is hardwired to 0.
  - Writes with waddr==0 are ignored.
  - Reads of address 0 always return 0, including when BYPASS=1 and we=1 with waddr==0; no forwarding is applied for address 0.
  - No storage is inferred for entry 0.
- Undefined: entry 0 is an ordinary writable register.

Test Plan (WIDTH=10, DEPTH=8, BYPASS=1 unless noted):
- Reset/basic write-read, READ_REG=0:
  - Stimulus: RST=1 one cycle; then write 10'h2A5 to addr 3; then raddr_a=3, raddr_b=4.
  - Response: rdata_a=10'h2A5, rdata_b=0. Any address read during reset returns 0 after the reset edge.
- Forwarding, READ_REG=0:
  - Stimulus: entry 5 holds 10'h001; same cycle we=1, waddr=5, wdata=10'h3FF, raddr_a=raddr_b=5.
  - Response: both outputs 10'h3FF before the edge.
  - With BYPASS=0, both outputs are 10'h001 before the edge and 10'h3FF after.
- Registered read, READ_REG=1:
  - Stimulus: raddr_a=3 presented at cycle n, where entry 3 = 10'h155.
  - Response: rdata_a=10'h155 from cycle n+1.
  - A simultaneous write of 10'h0AA to addr 3 at edge n yields 10'h0AA (BYPASS=1) or 10'h155 (BYPASS=0).
- Out-of-range and reset priority, DEPTH=6, AW=3:
  - Stimulus: write 10'h123 to addr 6; then read addr 6 and 7.
  - Response: both read 0 and entries 0-5 are unchanged.
  - Asserting RST and we together: the entry stays 0.
- REGFILE_ZERO_REG_EN:
  - Stimulus: write 10'h3C3 to addr 0 with raddr_a=0 in the same cycle.
  - Response: rdata_a=0 before and after the edge.
  - Without the macro: rdata_a=10'h3C3.
- Reset mid-read, READ_REG=1:
  - Stimulus: rdata_a=10'h155; RST pulsed one cycle.
  - Response: rdata_a=0 the next cycle and all entries read 0 afterwards.

Source files
------------

// File: rtl/regfile_nx10.sv
// DEPTH x WIDTH register file: one write port, two read ports, optional output registers.
// Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_nx10 #(
  parameter int WIDTH    = 10,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int READ_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

`ifdef REGFILE_ZERO_REG_EN
  localparam int LO = 1;
`else
  localparam int LO = 0;
`endif

  logic [WIDTH-1:0] ent [DEPTH];
  logic             wr_ok;
  logic             fwd_a;
  logic             fwd_b;
  logic [WIDTH-1:0] val_a_d;
  logic [WIDTH-1:0] val_b_d;

  // Qualified write: drops reset cycles, out-of-range and hardwired addresses
  assign wr_ok = we && !RST
              && (int'(waddr) < DEPTH)
              && (int'(waddr) >= LO);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    if (i < LO) begin : g_zero
      assign ent[i] = '0;
    end else begin : g_reg
      logic [WIDTH-1:0] ent_q;
      always_ff @(posedge CLK) begin
        if (RST) begin
          ent_q <= '0;
        end else if (wr_ok && waddr == AW'(i)) begin
          ent_q <= wdata;
        end
      end
      assign ent[i] = ent_q;
    end
  end

  assign fwd_a = (BYPASS != 0) && wr_ok
              && (raddr_a == waddr);
  assign fwd_b = (BYPASS != 0) && wr_ok
              && (raddr_b == waddr);

  always_comb begin
    val_a_d = '0;
    val_b_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == AW'(i)) val_a_d = ent[i];
      if (raddr_b == AW'(i)) val_b_d = ent[i];
    end
    if (fwd_a) val_a_d = wdata;
    if (fwd_b) val_b_d = wdata;
  end

  if (READ_REG != 0) begin : g_rreg
    logic [WIDTH-1:0] rdata_a_q;
    logic [WIDTH-1:0] rdata_b_q;
    always_ff @(posedge CLK) begin
      if (RST) begin
        rdata_a_q <= '0;
        rdata_b_q <= '0;
      end else begin
        rdata_a_q <= val_a_d;
        rdata_b_q <= val_b_d;
      end
    end
    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
  end else begin : g_comb
    assign rdata_a = val_a_d;
    assign rdata_b = val_b_d;
  end

endmodule

// File: tb/tb_regfile_nx10.sv
// Bench for regfile_nx10: five parameter variants on shared stimulus.
// Scoreboard queue of expected values, popped at each sample point.
module tb_regfile_nx10;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic       we  = 1'b0;
  logic [2:0] wa  = '0;
  logic [9:0] wd  = '0;
  logic [2:0] ra  = '0;
  logic [2:0] rb  = '0;
  logic [9:0] oa [5];
  logic [9:0] ob [5];

  always #5 CLK = ~CLK;

  // 0: comb/byp  1: comb/nobyp  2: reg/byp  3: reg/nobyp  4: comb/byp depth 6
  regfile_nx10 #(.READ_REG(0), .BYPASS(1)) u0 (
    .CLK(CLK), .RST(rst), .we(we), .waddr(wa), .wdata(wd),
    .raddr_a(ra), .raddr_b(rb), .rdata_a(oa[0]), .rdata_b(ob[0]));
  regfile_nx10 #(.READ_REG(0), .BYPASS(0)) u1 (
    .CLK(CLK), .RST(rst), .we(we), .waddr(wa), .wdata(wd),
    .raddr_a(ra), .raddr_b(rb), .rdata_a(oa[1]), .rdata_b(ob[1]));
  regfile_nx10 #(.READ_REG(1), .BYPASS(1)) u2 (
    .CLK(CLK), .RST(rst), .we(we), .waddr(wa), .wdata(wd),
    .raddr_a(ra), .raddr_b(rb), .rdata_a(oa[2]), .rdata_b(ob[2]));
  regfile_nx10 #(.READ_REG(1), .BYPASS(0)) u3 (
    .CLK(CLK), .RST(rst), .we(we), .waddr(wa), .wdata(wd),
    .raddr_a(ra), .raddr_b(rb), .rdata_a(oa[3]), .rdata_b(ob[3]));
  regfile_nx10 #(.DEPTH(6), .READ_REG(0), .BYPASS(1)) u4 (
    .CLK(CLK), .RST(rst), .we(we), .waddr(wa), .wdata(wd),
    .raddr_a(ra), .raddr_b(rb), .rdata_a(oa[4]), .rdata_b(ob[4]));

  typedef struct {
    string      tag;
    int         inst;
    bit         port;
    logic [9:0] exp;
  } sb_t;

  sb_t        q[$];
  int         total = 0;
  int         bad   = 0;
  logic [9:0] m8 [8];
  logic [9:0] m6 [8];
  logic [9:0] r2a = '0, r2b = '0, r3a = '0, r3b = '0;

  function automatic logic [9:0] mval(input bit d6, input bit byp,
                                      input logic [2:0] adr);
    int depth;
    depth = d6 ? 6 : 8;
    if (ZR && adr == 3'd0) return '0;
    if (byp && we && !rst && adr == wa && int'(wa) < depth) return wd;
    if (int'(adr) >= depth) return '0;
    return d6 ? m6[adr] : m8[adr];
  endfunction

  task automatic push(input string tag, input int inst, input bit port,
                      input logic [9:0] e);
    sb_t s;
    s.tag = tag; s.inst = inst; s.port = port; s.exp = e;
    q.push_back(s);
  endtask

  task automatic flush();
    sb_t        s;
    logic [9:0] o;
    while (q.size() > 0) begin
      s = q.pop_front();
      o = s.port ? ob[s.inst] : oa[s.inst];
      total++;
      assert (o === s.exp) else begin
        bad++;
        $error("FAIL %s inst%0d port%0d obs=%h exp=%h",
               s.tag, s.inst, s.port, o, s.exp);
      end
    end
  endtask

  task automatic drive(input bit r, input bit w, input logic [2:0] a_w,
                       input logic [9:0] d, input logic [2:0] a, input logic [2:0] b);
    @(negedge CLK);
    rst = r; we = w; wa = a_w; wd = d; ra = a; rb = b;
    #1;
  endtask

  task automatic pre();
    push("comb", 0, 0, mval(0, 1, ra)); push("comb", 0, 1, mval(0, 1, rb));
    push("comb", 1, 0, mval(0, 0, ra)); push("comb", 1, 1, mval(0, 0, rb));
    push("comb", 4, 0, mval(1, 1, ra)); push("comb", 4, 1, mval(1, 1, rb));
  endtask

  task automatic edge_();
    logic [9:0] n2a, n2b, n3a, n3b;
    n2a = rst ? '0 : mval(0, 1, ra); n2b = rst ? '0 : mval(0, 1, rb);
    n3a = rst ? '0 : mval(0, 0, ra); n3b = rst ? '0 : mval(0, 0, rb);
    @(posedge CLK);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m8[i] = '0; m6[i] = '0; end
    end else if (we && !(ZR && wa == 3'd0)) begin
      m8[wa] = wd;
      if (int'(wa) < 6) m6[wa] = wd;
    end
    r2a = n2a; r2b = n2b; r3a = n3a; r3b = n3b;
    #1;
    push("reg", 2, 0, r2a); push("reg", 2, 1, r2b);
    push("reg", 3, 0, r3a); push("reg", 3, 1, r3b);
  endtask

  task automatic step(input bit r, input bit w, input logic [2:0] a_w,
                      input logic [9:0] d, input logic [2:0] a, input logic [2:0] b);
    drive(r, w, a_w, d, a, b);
    pre(); flush();
    edge_(); flush();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m8[i] = '0; m6[i] = '0; end
    // reset with a write that must be dropped; no pre-edge check (power-up)
    drive(1, 1, 3, 10'h2A5, 3, 4);
    edge_();
    push("rst_reg_out", 2, 0, 10'h000);
    flush();
    // write 2A5 to 3, then read 3/4
    step(0, 1, 3, 10'h2A5, 3, 4);
    drive(0, 0, 0, 10'h000, 3, 4);
    pre();
    push("basic_a", 0, 0, 10'h2A5); push("basic_b", 0, 1, 10'h000);
    flush(); edge_(); flush();
    // forwarding on entry 5
    step(0, 1, 5, 10'h001, 0, 0);
    drive(0, 1, 5, 10'h3FF, 5, 5);
    pre();
    push("fwd_a", 0, 0, 10'h3FF); push("fwd_b", 0, 1, 10'h3FF);
    push("nofwd_a", 1, 0, 10'h001); push("nofwd_b", 1, 1, 10'h001);
    flush(); edge_(); flush();
    drive(0, 0, 0, 10'h000, 5, 5);
    pre();
    push("nofwd_after", 1, 0, 10'h3FF);
    flush(); edge_(); flush();
    // registered read, plain latency then same-edge write
    step(0, 1, 3, 10'h155, 0, 0);
    drive(0, 0, 0, 10'h000, 3, 3);
    pre(); flush(); edge_();
    push("rreg_lat", 2, 0, 10'h155); push("rreg_lat", 3, 0, 10'h155);
    flush();
    drive(0, 1, 3, 10'h0AA, 3, 3);
    pre(); flush(); edge_();
    push("rreg_byp", 2, 0, 10'h0AA); push("rreg_nobyp", 3, 0, 10'h155);
    flush();
    // out-of-range write to addr 6 on depth-6 instance
    drive(0, 1, 6, 10'h123, 6, 7);
    pre();
    push("oor_fwd", 4, 0, 10'h000); push("oor_fwd7", 4, 1, 10'h000);
    flush(); edge_(); flush();
    drive(0, 0, 0, 10'h000, 6, 7);
    pre();
    push("oor_rd6", 4, 0, 10'h000); push("oor_rd7", 4, 1, 10'h000);
    push("d8_rd6", 0, 0, 10'h123);
    flush(); edge_(); flush();
    for (int i = 0; i < 6; i += 2) step(0, 0, 0, 10'h000, 3'(i), 3'(i + 1));
    // registered output holds 155, then reset with simultaneous write
    step(0, 1, 3, 10'h155, 0, 0);
    drive(0, 0, 0, 10'h000, 3, 3);
    pre(); flush(); edge_();
    push("mid_pre", 2, 0, 10'h155);
    flush();
    drive(1, 1, 2, 10'h1AB, 3, 2);
    pre(); flush(); edge_();
    push("mid_rst_a", 2, 0, 10'h000); push("mid_rst_b", 3, 1, 10'h000);
    flush();
    for (int i = 0; i < 8; i += 2) begin
      drive(0, 0, 0, 10'h000, 3'(i), 3'(i + 1));
      pre();
      push("post_rst_a", 0, 0, 10'h000); push("post_rst_b", 0, 1, 10'h000);
      flush(); edge_(); flush();
    end
    // address 0 write: hardwired zero or ordinary entry
    drive(0, 1, 0, 10'h3C3, 0, 0);
    pre();
    push("z_pre", 0, 0, ZR ? 10'h000 : 10'h3C3);
    flush(); edge_(); flush();
    drive(0, 0, 0, 10'h000, 0, 0);
    pre();
    push("z_post", 0, 0, ZR ? 10'h000 : 10'h3C3);
    flush(); edge_(); flush();
    // random traffic against the model
    for (int n = 0; n < 60; n++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom), 3'($urandom),
           10'($urandom), 3'($urandom), 3'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
